game_controller: RTL and testbench

//   Top-level game sequencer for frogger. Owns the 2-bit game state bus that gates

---
 rtl/game_controller_if.sv | 26 ++
 rtl/game_controller.sv | 193 +++++++++++++++++++
 tb/tb_game_controller.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_controller_if.sv
// Game controller bus: inputs from the debouncers and the frog/lane datapath,
// outputs to the frog block and the video overlay.
// master = game_controller side, slave = surrounding datapath side.
interface game_controller_if;
    logic        frame_tick;
    logic        start_tick;
    logic        collision;
    logic        reached_end;
    logic [1:0]  state;
    logic        frog_reset;
    logic [2:0]  lives;
    logic [3:0]  level;
    logic [15:0] score;
    logic        game_over;
    logic [10:0] time_left;

    modport master (
        input  frame_tick, start_tick, collision, reached_end,
        output state, frog_reset, lives, level, score, game_over, time_left
    );

    modport slave (
        output frame_tick, start_tick, collision, reached_end,
        input  state, frog_reset, lives, level, score, game_over, time_left
    );
endinterface

// File: rtl/game_controller.sv
// Frogger game sequencer: MENU/PLAYING/DEAD/WIN state, respawn pulse,
// lives, level and score bookkeeping. All outputs registered.
// Optional per-life countdown timer enabled by defining GAME_TIMER_EN.
module game_controller #(
    parameter int unsigned START_LIVES = 3,
    parameter int unsigned DEAD_FRAMES = 90,
    parameter int unsigned WIN_FRAMES  = 120,
    parameter int unsigned MAX_LEVEL   = 15,
    parameter int unsigned TIME_FRAMES = 1800
) (
    input  logic              clk,
    input  logic              reset,
    game_controller_if.master bus
);

    typedef enum logic [1:0] {
        MENU    = 2'd0,
        PLAYING = 2'd1,
        DEAD    = 2'd2,
        WIN     = 2'd3
    } state_t;

    // Elaboration-time range guards on the configuration
    if (START_LIVES < 1 || START_LIVES > 7) begin : g_bad_lives
        $error("START_LIVES out of range");
    end
    if (MAX_LEVEL > 15) begin : g_bad_level
        $error("MAX_LEVEL out of range");
    end
    if (DEAD_FRAMES < 1 || WIN_FRAMES < 1 || DEAD_FRAMES > 65536 || WIN_FRAMES > 65536) begin : g_bad_frames
        $error("DEAD_FRAMES/WIN_FRAMES out of range");
    end
    if (TIME_FRAMES < 1 || TIME_FRAMES > 2047) begin : g_bad_time
        $error("TIME_FRAMES out of range");
    end

    localparam logic [2:0]  LIVES_INIT = 3'(START_LIVES);
    localparam logic [3:0]  LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [15:0] DEAD_LAST  = 16'(DEAD_FRAMES - 1);
    localparam logic [15:0] WIN_LAST   = 16'(WIN_FRAMES - 1);

    state_t      r_state,      w_state_nxt;
    logic        r_frog_reset, w_frog_reset_nxt;
    logic        r_mask;
    logic [2:0]  r_lives,      w_lives_nxt;
    logic [3:0]  r_level,      w_level_nxt;
    logic [15:0] r_score,      w_score_nxt;
    logic        r_game_over,  w_game_over_nxt;
    logic [15:0] r_frame_cnt,  w_frame_cnt_nxt;
    logic        w_masked;
    logic        w_timeout;
    logic        w_hit;
    logic        w_goal;

    // The frog's goal flag is stale during the respawn cycle and the one after
    assign w_masked = r_frog_reset | r_mask;
    assign w_hit    = (bus.collision & ~w_masked) | w_timeout;
    assign w_goal   = bus.reached_end & ~w_masked;

`ifdef GAME_TIMER_EN
    localparam logic [10:0] TIME_INIT = 11'(TIME_FRAMES);

    logic [10:0] r_time_left, w_time_left_nxt;

    // Timeout fires on the frame_tick that would take the budget to zero
    assign w_timeout = (r_state == PLAYING) &&
                       ((r_time_left == '0) || (bus.frame_tick && (r_time_left == 11'd1)));

    // Per-life budget: load on respawn, count down while playing, clear in menu
    always_comb begin
        w_time_left_nxt = r_time_left;
        if (w_frog_reset_nxt) begin
            w_time_left_nxt = TIME_INIT;
        end else if (w_state_nxt == MENU) begin
            w_time_left_nxt = '0;
        end else if ((r_state == PLAYING) && bus.frame_tick && (r_time_left != '0)) begin
            w_time_left_nxt = r_time_left - 11'd1;
        end
    end

    // Timer register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_time_left <= '0;
        end else begin
            r_time_left <= w_time_left_nxt;
        end
    end

    assign bus.time_left = r_time_left;
`else
    assign w_timeout     = 1'b0;
    assign bus.time_left = '0;
`endif

    // Next-state and bookkeeping logic
    always_comb begin
        w_state_nxt      = r_state;
        w_frog_reset_nxt = 1'b0;
        w_lives_nxt      = r_lives;
        w_level_nxt      = r_level;
        w_score_nxt      = r_score;
        w_frame_cnt_nxt  = r_frame_cnt;
        case (r_state)
            MENU: begin
                if (bus.start_tick) begin
                    w_state_nxt      = PLAYING;
                    w_frog_reset_nxt = 1'b1;
                    w_lives_nxt      = LIVES_INIT;
                    w_level_nxt      = '0;
                    w_score_nxt      = '0;
                end
            end
            PLAYING: begin
                if (w_hit) begin
                    w_state_nxt     = DEAD;
                    w_frame_cnt_nxt = '0;
                    if (r_lives != '0) begin
                        w_lives_nxt = r_lives - 3'd1;
                    end
                end else if (w_goal) begin
                    w_state_nxt     = WIN;
                    w_frame_cnt_nxt = '0;
                    if (r_score != '1) begin
                        w_score_nxt = r_score + 16'd1;
                    end
                    if (r_level < LEVEL_MAX) begin
                        w_level_nxt = r_level + 4'd1;
                    end
                end
            end
            DEAD: begin
                if (r_lives == '0) begin
                    if (bus.start_tick) begin
                        w_state_nxt = MENU;
                    end
                end else if (bus.frame_tick) begin
                    if (r_frame_cnt == DEAD_LAST) begin
                        w_state_nxt      = PLAYING;
                        w_frog_reset_nxt = 1'b1;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                    end
                end
            end
            WIN: begin
                if (bus.frame_tick) begin
                    if (r_frame_cnt == WIN_LAST) begin
                        w_state_nxt      = PLAYING;
                        w_frog_reset_nxt = 1'b1;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = MENU;
            end
        endcase
        w_game_over_nxt = (w_state_nxt == DEAD) && (w_lives_nxt == '0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= MENU;
            r_frog_reset <= 1'b0;
            r_mask       <= 1'b0;
            r_lives      <= LIVES_INIT;
            r_level      <= '0;
            r_score      <= '0;
            r_game_over  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_frog_reset <= w_frog_reset_nxt;
            r_mask       <= r_frog_reset;
            r_lives      <= w_lives_nxt;
            r_level      <= w_level_nxt;
            r_score      <= w_score_nxt;
            r_game_over  <= w_game_over_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
        end
    end

    assign bus.state      = r_state;
    assign bus.frog_reset = r_frog_reset;
    assign bus.lives      = r_lives;
    assign bus.level      = r_level;
    assign bus.score      = r_score;
    assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_game_controller;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    game_controller_if gif ();

    game_controller #(
        .START_LIVES(3),
        .DEAD_FRAMES(90),
        .WIN_FRAMES (120),
        .MAX_LEVEL  (15),
        .TIME_FRAMES(1800)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (gif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        gif.start_tick = 1'b1;
        step();
        gif.start_tick = 1'b0;
    endtask

    task automatic pulse_collision();
        gif.collision = 1'b1;
        step();
        gif.collision = 1'b0;
    endtask

    task automatic pulse_goal();
        gif.reached_end = 1'b1;
        step();
        gif.reached_end = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            gif.frame_tick = 1'b1;
            step();
        end
        gif.frame_tick = 1'b0;
    endtask

    // Start a game and step past the post-respawn input mask window
    task automatic start_and_settle();
        pulse_start();
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        n_checks++;
        if (gif.state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", gif.state); end
        n_checks++;
        if (gif.frog_reset !== 1'b0) begin n_errors++; $display("FAIL reset_frog: got %0b expected 0", gif.frog_reset); end
        n_checks++;
        if (gif.lives !== 3'd3) begin n_errors++; $display("FAIL reset_lives: got %0d expected 3", gif.lives); end
        n_checks++;
        if (gif.level !== 4'd0 || gif.score !== 16'd0) begin
            n_errors++; $display("FAIL reset_level_score: got %0d/%0d expected 0/0", gif.level, gif.score);
        end
        n_checks++;
        if (gif.game_over !== 1'b0 || gif.time_left !== 11'd0) begin
            n_errors++; $display("FAIL reset_over_time: got %0b/%0d expected 0/0", gif.game_over, gif.time_left);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (gif.state !== 2'd0) begin n_errors++; $display("FAIL menu_idle: got %0d expected 0", gif.state); end
    endtask

    task automatic test_start();
        do_reset();
        pulse_start();
        n_checks++;
        if (gif.state !== 2'd1 || gif.frog_reset !== 1'b1) begin
            n_errors++; $display("FAIL start_state_frog: got %0d/%0b expected 1/1", gif.state, gif.frog_reset);
        end
        n_checks++;
        if (gif.lives !== 3'd3 || gif.level !== 4'd0 || gif.score !== 16'd0) begin
            n_errors++; $display("FAIL start_counters: got %0d/%0d/%0d expected 3/0/0", gif.lives, gif.level, gif.score);
        end
`ifdef GAME_TIMER_EN
        n_checks++;
        if (gif.time_left !== 11'd1800) begin n_errors++; $display("FAIL start_time: got %0d expected 1800", gif.time_left); end
`else
        n_checks++;
        if (gif.time_left !== 11'd0) begin n_errors++; $display("FAIL start_time: got %0d expected 0", gif.time_left); end
`endif
        step();
        n_checks++;
        if (gif.frog_reset !== 1'b0 || gif.state !== 2'd1) begin
            n_errors++; $display("FAIL start_pulse_width: got %0b/%0d expected 0/1", gif.frog_reset, gif.state);
        end
        // start_tick is ignored while playing
        pulse_start();
        n_checks++;
        if (gif.state !== 2'd1 || gif.frog_reset !== 1'b0) begin
            n_errors++; $display("FAIL start_ignored_playing: got %0d/%0b expected 1/0", gif.state, gif.frog_reset);
        end
    endtask

    task automatic test_mask();
        do_reset();
        pulse_start();
        gif.collision = 1'b1;
        step();
        n_checks++;
        if (gif.state !== 2'd1) begin n_errors++; $display("FAIL mask_frog_cycle: got %0d expected 1", gif.state); end
        step();
        n_checks++;
        if (gif.state !== 2'd1) begin n_errors++; $display("FAIL mask_next_cycle: got %0d expected 1", gif.state); end
        step();
        gif.collision = 1'b0;
        n_checks++;
        if (gif.state !== 2'd2 || gif.lives !== 3'd2) begin
            n_errors++; $display("FAIL mask_release: got %0d/%0d expected 2/2", gif.state, gif.lives);
        end
    endtask

    task automatic test_death_respawn();
        do_reset();
        start_and_settle();
        pulse_collision();
        n_checks++;
        if (gif.state !== 2'd2 || gif.lives !== 3'd2 || gif.game_over !== 1'b0) begin
            n_errors++; $display("FAIL death_enter: got %0d/%0d/%0b expected 2/2/0", gif.state, gif.lives, gif.game_over);
        end
        frames(89);
        n_checks++;
        if (gif.state !== 2'd2) begin n_errors++; $display("FAIL death_89: got %0d expected 2", gif.state); end
        frames(1);
        n_checks++;
        if (gif.state !== 2'd1 || gif.frog_reset !== 1'b1) begin
            n_errors++; $display("FAIL death_respawn: got %0d/%0b expected 1/1", gif.state, gif.frog_reset);
        end
        step();
        n_checks++;
        if (gif.frog_reset !== 1'b0) begin n_errors++; $display("FAIL death_pulse_width: got %0b expected 0", gif.frog_reset); end
    endtask

    task automatic test_collision_priority();
        do_reset();
        start_and_settle();
        gif.collision   = 1'b1;
        gif.reached_end = 1'b1;
        step();
        gif.collision   = 1'b0;
        gif.reached_end = 1'b0;
        n_checks++;
        if (gif.state !== 2'd2 || gif.score !== 16'd0 || gif.level !== 4'd0) begin
            n_errors++; $display("FAIL priority: got %0d/%0d/%0d expected 2/0/0", gif.state, gif.score, gif.level);
        end
    endtask

    task automatic test_game_over();
        do_reset();
        start_and_settle();
        for (int i = 0; i < 3; i++) begin
            pulse_collision();
            n_checks++;
            if (gif.lives !== 3'(2 - i) || gif.state !== 2'd2) begin
                n_errors++; $display("FAIL over_life_%0d: got %0d/%0d expected %0d/2", i, gif.lives, gif.state, 2 - i);
            end
            if (i < 2) begin
                frames(90);
                step();
                step();
            end
        end
        n_checks++;
        if (gif.game_over !== 1'b1) begin n_errors++; $display("FAIL over_flag: got %0b expected 1", gif.game_over); end
        frames(200);
        n_checks++;
        if (gif.state !== 2'd2 || gif.game_over !== 1'b1 || gif.frog_reset !== 1'b0) begin
            n_errors++; $display("FAIL over_hold: got %0d/%0b/%0b expected 2/1/0", gif.state, gif.game_over, gif.frog_reset);
        end
        pulse_collision();
        n_checks++;
        if (gif.lives !== 3'd0) begin n_errors++; $display("FAIL over_no_wrap: got %0d expected 0", gif.lives); end
        pulse_start();
        n_checks++;
        if (gif.state !== 2'd0 || gif.game_over !== 1'b0) begin
            n_errors++; $display("FAIL over_to_menu: got %0d/%0b expected 0/0", gif.state, gif.game_over);
        end
        pulse_start();
        n_checks++;
        if (gif.state !== 2'd1 || gif.lives !== 3'd3) begin
            n_errors++; $display("FAIL over_restart: got %0d/%0d expected 1/3", gif.state, gif.lives);
        end
    endtask

    task automatic test_win_levels();
        int exp_lv;
        do_reset();
        start_and_settle();
        for (int i = 0; i < 16; i++) begin
            pulse_goal();
            exp_lv = (i + 1 > 15) ? 15 : i + 1;
            n_checks++;
            if (gif.state !== 2'd3 || gif.score !== 16'(i + 1) || gif.level !== 4'(exp_lv)) begin
                n_errors++;
                $display("FAIL win_%0d: got %0d/%0d/%0d expected 3/%0d/%0d", i, gif.state, gif.score, gif.level, i + 1, exp_lv);
            end
            if (i == 0) begin
                pulse_start();
                n_checks++;
                if (gif.state !== 2'd3) begin n_errors++; $display("FAIL start_ignored_win: got %0d expected 3", gif.state); end
            end
            frames(119);
            n_checks++;
            if (gif.state !== 2'd3) begin n_errors++; $display("FAIL win_hold_%0d: got %0d expected 3", i, gif.state); end
            frames(1);
            n_checks++;
            if (gif.state !== 2'd1 || gif.frog_reset !== 1'b1) begin
                n_errors++; $display("FAIL win_exit_%0d: got %0d/%0b expected 1/1", i, gif.state, gif.frog_reset);
            end
            step();
            step();
        end
        n_checks++;
        if (gif.level !== 4'd15 || gif.score !== 16'd16) begin
            n_errors++; $display("FAIL win_final: got %0d/%0d expected 15/16", gif.level, gif.score);
        end
    endtask

    task automatic test_reset_midgame();
        do_reset();
        start_and_settle();
        pulse_goal();
        frames(10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (gif.state !== 2'd0 || gif.score !== 16'd0 || gif.lives !== 3'd3) begin
            n_errors++; $display("FAIL reset_mid_win: got %0d/%0d/%0d expected 0/0/3", gif.state, gif.score, gif.lives);
        end
    endtask

`ifdef GAME_TIMER_EN
    task automatic test_timer();
        do_reset();
        pulse_start();
        frames(1799);
        n_checks++;
        if (gif.state !== 2'd1 || gif.time_left !== 11'd1) begin
            n_errors++; $display("FAIL timer_1799: got %0d/%0d expected 1/1", gif.state, gif.time_left);
        end
        frames(1);
        n_checks++;
        if (gif.state !== 2'd2 || gif.lives !== 3'd2 || gif.time_left !== 11'd0) begin
            n_errors++; $display("FAIL timer_expire: got %0d/%0d/%0d expected 2/2/0", gif.state, gif.lives, gif.time_left);
        end
    endtask
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        reset            = 1'b1;
        gif.frame_tick   = 1'b0;
        gif.start_tick   = 1'b0;
        gif.collision    = 1'b0;
        gif.reached_end  = 1'b0;
        test_reset();
        test_start();
        test_mask();
        test_death_respawn();
        test_collision_priority();
        test_game_over();
        test_win_levels();
        test_reset_midgame();
`ifdef GAME_TIMER_EN
        test_timer();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
